pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It produces the write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers, and the PC source select. Three events drive it: load-use hazards, taken branches resolved in MEM, and data-memory wait states signalled by a ready handshake. It sits beside the datapath, reading stage fields and driving every stage register's control pins.

Parameters:
CNT_W, 16, width of the saturating stall/flush performance counters
WAIT_W, 4, width of the memory-wait cycle counter
MAX_WAIT, 12, wait cycles after which mem_timeout is raised (must be < 2^WAIT_W)

Ports:
clk  in  1  rising-edge clock
startin  in  1  synchronous active-high reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
EX_mem_read  in  1  the instruction in EX is a load
EX_rt  in  5  destination register of the load in EX
MEM_branch  in  1  the instruction in MEM is a branch
MEM_zero  in  1  ALU zero flag of the instruction in MEM
MEM_mem_read  in  1  the instruction in MEM reads memory
MEM_mem_write  in  1  the instruction in MEM writes memory
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
IF_ID_write  out  1  IF/ID load enable
IF_ID_flush  out  1  clear IF/ID to a bubble
ID_EX_write  out  1  ID/EX load enable
ID_EX_flush  out  1  load a bubble (zero control) into ID/EX
EX_MEM_write  out  1  EX/MEM load enable
EX_MEM_flush  out  1  load a bubble into EX/MEM
pc_src  out  1  1 = select the MEM branch target
ctrl_state  out  2  current FSM state
stall_count  out  CNT_W  cycles spent stalled (load-use + memory wait)
flush_count  out  CNT_W  taken-branch flush events
mem_timeout  out  1  sticky flag: memory wait exceeded MAX_WAIT

Behaviour:
- Reset: one clock; synchronous, active-high on startin. The decision is fixed.
- While startin=1: all *_write=0, all *_flush=1, pc_src=0. Registered state on the next edge: state=S_RUN, wait counter=0, both counters=0, mem_timeout=0.
- Control outputs are combinational from the registered state and the current inputs. They act on the same clock edge, so there is zero-cycle latency.
- Default (no event): all writes=1, all flushes=0, pc_src=0.
- mem_busy = (MEM_mem_read | MEM_mem_write) & ~mem_ready.
- br_taken = MEM_branch & MEM_zero.
- lu_hazard = EX_mem_read & (EX_rt != 0) & (EX_rt == ID_rs | EX_rt == ID_rt).
- Priority: mem_busy > br_taken > lu_hazard.
- mem_busy: all four write enables=0 and no flushes, so the whole pipe freezes. Next state is S_MEM_WAIT and the wait counter increments.
  - When the wait counter reaches MAX_WAIT, mem_timeout is set. It stays set until reset.
  - The pipe keeps waiting after a timeout; the access is not abandoned.
  - The wait counter saturates and clears when mem_busy deasserts.
- br_taken (mem not busy): pc_src=1, IF_ID_flush=1, ID_EX_flush=1, EX_MEM_flush=1, writes=1. Next state is S_BR_FLUSH and flush_count increments.
- lu_hazard (no higher event): pc_write=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM_write=1. Next state is S_LOAD_STALL.
- S_LOAD_STALL and S_BR_FLUSH last one cycle each, then return to S_RUN unless a new event occurs. In S_BR_FLUSH, lu_hazard is ignored because ID holds a bubble.
- S_MEM_WAIT returns to S_RUN on the first cycle mem_busy=0. That cycle evaluates br_taken and lu_hazard normally.
- stall_count increments on every cycle with mem_busy or an applied lu_hazard.
- Both counters saturate at all-ones and never wrap.
- Simultaneous br_taken + lu_hazard: branch wins and no stall is taken, since the ID instruction is squashed.
- mem_busy + br_taken: freeze only. The branch stays frozen in EX/MEM and is taken on the cycle ready arrives.
- startin asserted mid-S_MEM_WAIT or mid-stall: reset wins in the same cycle.
- State encoding: S_RUN=0, S_LOAD_STALL=1, S_BR_FLUSH=2, S_MEM_WAIT=3.

Decomposition:
- Package pipe_ctrl_pkg holds the state enum/encodings, REG_ZERO=5'd0, and defaults for CNT_W/WAIT_W/MAX_WAIT.
- Sub-module load_use_detect is combinational. Inputs: EX_mem_read, EX_rt, ID_rs, ID_rt. Output: lu_hazard.
- The FSM, counters and output decode stay in pipe_hazard_ctrl.

Test Plan:
1. Reset: startin=1 for 2 cycles, then 0 with quiet inputs -> during reset all flushes=1 and writes=0; afterwards ctrl_state=0, writes=1, counters=0.
2. Load-use: EX_mem_read=1, EX_rt=5, ID_rs=5 for one cycle -> pc_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle ctrl_state=1 and stall_count=1. With EX_rt=0 -> no stall.
3. Taken branch: MEM_branch=1, MEM_zero=1 -> pc_src=1 and all three flushes=1 for one cycle; flush_count=1; ctrl_state=2, then 0. With MEM_zero=0 -> no action.
4. Memory wait: MEM_mem_read=1, mem_ready=0 for 3 cycles, then ready=1 -> all writes=0 for 3 cycles, stall_count=3, ctrl_state=3, then 0, mem_timeout=0.
5. Timeout + reset: mem_ready held 0 for 14 cycles -> mem_timeout=1 from cycle 12 and stays set after ready returns. Asserting startin mid-wait -> state 0 and flag cleared next edge.
6. Priority: mem_busy + br_taken + lu_hazard together -> freeze only. When ready arrives -> branch flush is taken and the load-use stall is suppressed.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_BR_FLUSH   = 2'd2,
    S_MEM_WAIT   = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CNT_W_DEF    = 16;
  localparam int WAIT_W_DEF   = 4;
  localparam int MAX_WAIT_DEF = 12;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in ID reads. Register zero never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       EX_mem_read,
  input  logic [4:0] EX_rt,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  output logic       lu_hazard
);

  // Pure combinational compare of the load destination against ID sources.
  always_comb begin
    lu_hazard = EX_mem_read & (EX_rt != REG_ZERO) &
                ((EX_rt == ID_rs) | (EX_rt == ID_rt));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes and freezes the 5-stage
// pipe for load-use hazards, taken branches and data-memory wait states.
//
// state        | meaning
// S_RUN        | normal flow, no event last cycle
// S_LOAD_STALL | a load-use bubble was inserted last cycle
// S_BR_FLUSH   | a taken branch squashed IF/ID/EX last cycle (ID holds a bubble)
// S_MEM_WAIT   | pipe frozen waiting for data memory
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WAIT_W   = WAIT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             startin,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_rt,
  input  logic             MEM_branch,
  input  logic             MEM_zero,
  input  logic             MEM_mem_read,
  input  logic             MEM_mem_write,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             EX_MEM_flush,
  output logic             pc_src,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_PRE   = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  ctrl_state_t       state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu_hazard, mem_busy, br_taken, lu_apply;

  load_use_detect u_lu (
    .EX_mem_read (EX_mem_read),
    .EX_rt       (EX_rt),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .lu_hazard   (lu_hazard)
  );

  // Event qualification with priority mem_busy > br_taken > lu_hazard.
  always_comb begin
    mem_busy = (MEM_mem_read | MEM_mem_write) & ~mem_ready;
    br_taken = MEM_branch & MEM_zero & ~mem_busy;
    lu_apply = lu_hazard & ~mem_busy & ~br_taken & (state != S_BR_FLUSH);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (startin) state <= S_RUN;
    else         state <= state_next;
  end

  // Next-state selection; every state re-evaluates events each cycle.
  always_comb begin
    state_next = S_RUN;
    if (mem_busy)      state_next = S_MEM_WAIT;
    else if (br_taken) state_next = S_BR_FLUSH;
    else if (lu_apply) state_next = S_LOAD_STALL;
  end

  // Stage register controls, combinational so they act on this edge.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    EX_MEM_flush = 1'b0;
    pc_src       = 1'b0;
    if (startin) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
    end else if (br_taken) begin
      pc_src       = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (lu_apply) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

  // Wait counter, sticky timeout and saturating performance counters.
  always_ff @(posedge clk) begin
    if (startin) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (mem_busy) begin
        if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt >= WAIT_PRE)   mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if ((mem_busy | lu_apply) && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_W'(1);
      if (br_taken && flush_count != CNT_MAX)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, compared against an event-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W    = 6;
  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 12;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic startin = 1'b1;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
  logic EX_mem_read = 0, MEM_branch = 0, MEM_zero = 0;
  logic MEM_mem_read = 0, MEM_mem_write = 0, mem_ready = 1;
  logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic EX_MEM_write, EX_MEM_flush, pc_src, mem_timeout;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit m_valid = 0;
  int m_state = 0;
  int m_busy_run = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_timeout = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .startin(startin),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_mem_read(EX_mem_read), .EX_rt(EX_rt),
    .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_write(EX_MEM_write), .EX_MEM_flush(EX_MEM_flush),
    .pc_src(pc_src), .ctrl_state(ctrl_state),
    .stall_count(stall_count), .flush_count(flush_count),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance model.
  task automatic step(input bit rst, input bit emr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input bit br, input bit z, input bit rd, input bit wr,
                      input bit rdy);
    bit busy, brt, lu, lu_ok;
    bit e_pcw, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_src;
    @(negedge clk);
    startin = rst; EX_mem_read = emr; EX_rt = ert; ID_rs = rs; ID_rt = rt;
    MEM_branch = br; MEM_zero = z; MEM_mem_read = rd; MEM_mem_write = wr;
    mem_ready = rdy;
    #1;
    busy  = (rd || wr) && !rdy;
    brt   = br && z;
    lu    = emr && (ert != 0) && (ert == rs || ert == rt);
    lu_ok = lu && !busy && !brt && (m_state != 2);

    {e_pcw, e_ifw, e_idw, e_exw} = 4'b1111;
    {e_iff, e_idf, e_exf, e_src} = 4'b0000;
    if (rst) begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b0000;
      {e_iff, e_idf, e_exf} = 3'b111;
    end else if (busy) begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b0000;
    end else if (brt) begin
      {e_iff, e_idf, e_exf, e_src} = 4'b1111;
    end else if (lu_ok) begin
      e_pcw = 0; e_ifw = 0; e_idf = 1;
    end

    check("controls",
          {24'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, EX_MEM_flush, pc_src},
          {24'd0, e_pcw, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_src});
    if (m_valid) begin
      check("ctrl_state", 32'(ctrl_state), 32'(m_state));
      check("stall_count", 32'(stall_count), 32'(m_stall));
      check("flush_count", 32'(flush_count), 32'(m_flush));
      check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
    end

    @(posedge clk);
    if (rst) begin
      m_valid = 1; m_state = 0; m_busy_run = 0;
      m_stall = 0; m_flush = 0; m_timeout = 0;
    end else if (busy) begin
      m_busy_run++;
      if (m_busy_run >= MAX_WAIT) m_timeout = 1;
      if (m_stall < CNT_SAT) m_stall++;
      m_state = 3;
    end else begin
      m_busy_run = 0;
      if (brt) begin
        if (m_flush < CNT_SAT) m_flush++;
        m_state = 2;
      end else if (lu_ok) begin
        if (m_stall < CNT_SAT) m_stall++;
        m_state = 1;
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic quiet(input bit rst);
    step(rst, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int hold;
    // reset for two cycles, then idle
    quiet(1); quiet(1); quiet(0); quiet(0);
    // load-use on rs, then EX_rt = 0 gives no stall
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 1);
    quiet(0);
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    step(0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 1);
    quiet(0);
    // taken and not-taken branch
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    quiet(0); quiet(0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1);
    // branch flush followed by a load-use pattern that must be ignored
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0, 1);
    quiet(0);
    // three-cycle memory wait
    repeat (3) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    quiet(0);
    // long wait: timeout sets and stays after ready returns
    repeat (14) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    quiet(0);
    // reset asserted mid-wait
    repeat (4) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    quiet(0);
    // all three events together, then ready arrives
    repeat (2) step(0, 1, 5'd4, 5'd4, 5'd4, 1, 1, 1, 0, 0);
    step(0, 1, 5'd4, 5'd4, 5'd4, 1, 1, 1, 0, 1);
    quiet(0); quiet(0);

    // randomized traffic with occasional long memory waits and resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rd, wr, rdy, rst;
      rst = ($urandom_range(0, 99) == 0);
      if (hold == 0 && $urandom_range(0, 39) == 0) hold = $urandom_range(5, 16);
      rd  = ($urandom_range(0, 2) == 0);
      wr  = !rd && ($urandom_range(0, 3) == 0);
      if (hold > 0) begin
        rd = 1; rdy = 0; hold--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      step(rst, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rd, wr, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
